// File: rtl/onehot_decoder_scan_if.sv
// Select/scan bus for onehot_decoder_scan: control inputs toward the decoder,
// registered one-hot result and status back to the consumer.
interface onehot_decoder_scan_if #(
    parameter int IN_W    = 3,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = 2**IN_W;

    logic               en;
    logic [1:0]         mode;
    logic [IN_W-1:0]    in_sel;
    logic               in_valid;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic               out_valid;
    logic [IN_W-1:0]    cur_idx;
    logic               wrap;

    modport master (
        output en, mode, in_sel, in_valid, dwell,
        input  out, out_valid, cur_idx, wrap
    );

    modport slave (
        input  en, mode, in_sel, in_valid, dwell,
        output out, out_valid, cur_idx, wrap
    );
endinterface

// File: rtl/onehot_decoder_scan.sv
// Binary-to-one-hot decoder with registered output, plus an up/down channel
// scan sequencer with programmable dwell and a hold mode.
module onehot_decoder_scan #(
    parameter int IN_W    = 3,
    parameter int DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    onehot_decoder_scan_if.slave bus
);
    localparam int OUT_W = 2**IN_W;
    localparam logic [IN_W-1:0] IDX_MAX = IN_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, HOLD} state_t;
    typedef enum logic [1:0] {M_DIRECT, M_SCAN_UP, M_SCAN_DN, M_HOLD} mode_t;

    state_t             st, st_n;
    logic               dn, dn_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [IN_W-1:0]    idx, idx_n;
    logic               vld, vld_n;
    logic               wrap_q, wrap_n;
    logic [OUT_W-1:0]   out_q, out_n;
    logic               entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            dn     <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            vld    <= 1'b0;
            wrap_q <= 1'b0;
            out_q  <= '0;
        end else begin
            st     <= st_n;
            dn     <= dn_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            vld    <= vld_n;
            wrap_q <= wrap_n;
            out_q  <= out_n;
        end
    end

    always_comb begin
        st_n   = st;
        dn_n   = dn;
        cnt_n  = cnt;
        idx_n  = idx;
        vld_n  = vld;
        wrap_n = 1'b0;
        entry  = 1'b0;
        if (!bus.en) begin
            st_n  = IDLE;
            vld_n = 1'b0;
            cnt_n = '0;
        end else begin
            case (mode_t'(bus.mode))
                M_DIRECT: begin
                    st_n = DIRECT;
                    if (bus.in_valid) begin
                        idx_n = bus.in_sel;
                        vld_n = 1'b1;
                    end
                end
                M_SCAN_UP, M_SCAN_DN: begin
                    st_n  = SCAN;
                    dn_n  = (bus.mode == M_SCAN_DN);
                    vld_n = 1'b1;
                    // Entering scan or reversing direction restarts the dwell
                    // from the current index without stepping.
                    entry = (st != SCAN) || (dn != dn_n);
                    if (entry) begin
                        cnt_n = '0;
                    end else if (cnt >= bus.dwell) begin
                        cnt_n = '0;
                        if (dn_n) begin
                            idx_n  = idx - IN_W'(1);
                            wrap_n = (idx == '0);
                        end else begin
                            idx_n  = idx + IN_W'(1);
                            wrap_n = (idx == IDX_MAX);
                        end
                    end else begin
                        cnt_n = cnt + DWELL_W'(1);
                    end
                end
                M_HOLD: st_n = HOLD;
                default: begin
                    st_n  = IDLE;
                    vld_n = 1'b0;
                    cnt_n = '0;
                end
            endcase
        end
        out_n = vld_n ? (OUT_W'(1) << idx_n) : '0;
    end

    assign bus.out       = out_q;
    assign bus.out_valid = vld;
    assign bus.cur_idx   = idx;
    assign bus.wrap      = wrap_q;
endmodule
